// File: rtl/uart_pkg.sv
// Shared UART types: byte type and the transmit launcher state encoding.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_launch_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular FIFO with wrapping read/write pointers and a separate occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    rp_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rp_q];
    assign count    = count_q;

    // Pointers wrap naturally at DEPTH (power of two); count moves only on unbalanced traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: accepts bytes over valid/ready, pops one at a time
// and launches it through the uart_tx data/start/ready handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             tx_data,
    output logic                         tx_start,
    input  logic                         tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drained
);

    tx_launch_state_e state_q;
    tx_launch_state_e state_d;
    logic             out_of_reset_q;
    logic [WIDTH-1:0] tx_data_q;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // in_ready stays low while rst is high and until the first clock after release.
    assign in_ready = out_of_reset_q && !fifo_full;
    assign push     = in_valid && in_ready;
    assign tx_data  = tx_data_q;
    assign drained  = (state_q == IDLE) && fifo_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Launcher next-state: pop on IDLE->LAUNCH, pulse start, then follow uart_tx ready low/high.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && tx_ready) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Launcher state register and out-of-reset flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            out_of_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_of_reset_q <= 1'b1;
        end
    end

    // Byte in flight: captured on pop and held until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q <= '0;
        end else if (pop) begin
            tx_data_q <= fifo_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural uart_tx stand-in.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_start;
    logic             tx_ready;
    logic [CW-1:0]    count;
    logic             drained;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference: bytes accepted but not yet launched, in order.
    logic [WIDTH-1:0] exp_q [$];

    // uart_tx stand-in state
    logic             hold = 1'b0;
    bit               busy = 1'b0;
    int               drop_cnt = 0;
    int               frame_cnt = 0;
    int               idle_cnt = 0;
    int               n_launch = 0;
    logic [WIDTH-1:0] cur;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .count    (count),
        .drained  (drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: on start, take the byte, drop ready after 1-3 cycles, raise it
    // again after a random frame time. hold keeps ready low while idle.
    initial begin
        logic [WIDTH-1:0] want;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                busy     = 1'b0;
                tx_ready = 1'b1;
                idle_cnt = 0;
                continue;
            end
            if (busy) begin
                chk("tx_data_stable", tx_data, cur);
                chk("no_start_busy", tx_start, 1'b0);
                chk("drained_busy", drained, 1'b0);
                if (drop_cnt > 0) begin
                    drop_cnt--;
                    if (drop_cnt == 0) tx_ready = 1'b0;
                end else if (frame_cnt > 0) begin
                    frame_cnt--;
                    if (frame_cnt == 0) begin
                        tx_ready = 1'b1;
                        busy     = 1'b0;
                        idle_cnt = 0;
                    end
                end
            end else if (tx_start === 1'b1) begin
                n_launch++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 1'b1, 1'b0);
                end else begin
                    want = exp_q.pop_front();
                    chk("tx_byte", tx_data, want);
                end
                cur       = tx_data;
                busy      = 1'b1;
                drop_cnt  = $urandom_range(1, 3);
                frame_cnt = $urandom_range(2, 10);
            end else begin
                idle_cnt++;
                tx_ready = !hold;
                if (exp_q.size() == 0 && idle_cnt >= 2) chk("drained_idle", drained, 1'b1);
            end
        end
    end

    // One cycle: drive inputs, check occupancy/ready at negedge, record acceptance.
    task automatic step(input logic v, input logic [WIDTH-1:0] d);
        logic exp_rdy;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        exp_rdy = (exp_q.size() < DEPTH);
        chk("count", count, exp_q.size());
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk); #1;
        if (v && exp_rdy) exp_q.push_back(d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && idle_cnt >= 3) && n < 600) begin
            step(1'b0, '0);
            n++;
        end
        chk("drain_timeout", (n < 600), 1'b1);
        chk("drained_end", drained, 1'b1);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_pre_clk", in_ready, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int n;

        // Reset hold with a producer pushing throughout
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_tx_start", tx_start, 1'b0);
            chk("rst_count", count, 0);
            chk("rst_drained", drained, 1'b1);
        end
        chk("rst_tx_data", tx_data, 8'h00);
        release_reset();

        // Single byte into an idle FIFO: start pulse in the cycle after the pop edge
        step(1'b0, '0);
        in_valid = 1'b1;
        in_data  = 8'hD5;
        @(negedge clk);
        chk("single_start_pre", tx_start, 1'b0);
        @(posedge clk); #1;
        exp_q.push_back(8'hD5);
        in_valid = 1'b0;
        chk("single_start_push_edge", tx_start, 1'b0);
        chk("single_count", count, 1);
        @(posedge clk); #1;
        chk("single_start", tx_start, 1'b1);
        chk("single_data", tx_data, 8'hD5);
        @(posedge clk); #1;
        chk("single_start_once", tx_start, 1'b0);
        drain();

        // Burst of four bytes on consecutive cycles
        step(1'b1, 8'hD5);
        step(1'b1, 8'hBD);
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        drain();

        // Full: launcher blocked, six pushes, only DEPTH accepted
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i));
        step(1'b0, '0);
        chk("full_count", count, DEPTH);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_accepted", exp_q.size(), DEPTH);
        hold = 1'b0;
        drain();

        // Randomized traffic with random back-pressure from the transmitter
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) hold = !hold;
            step(($urandom_range(0, 2) != 0), 8'($urandom));
        end
        hold = 1'b0;
        drain();

        // Reset during the second of three queued frames
        base = n_launch;
        step(1'b1, 8'h3C);
        step(1'b1, 8'hC3);
        step(1'b1, 8'h5A);
        n = 0;
        while (n_launch < base + 2 && n < 300) begin
            step(1'b0, '0);
            n++;
        end
        chk("second_frame_timeout", (n < 300), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_drained", drained, 1'b1);
        chk("midrst_tx_start", tx_start, 1'b0);
        chk("midrst_count", count, 0);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 30; i++) step(1'b0, '0);
        chk("post_rst_no_launch", n_launch, base + 2);
        chk("post_rst_drained", drained, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
